// File: rtl/data_bus_responder.sv
// Memory-mapped word storage that answers byte/half/word loads and stores
// with a fixed, parameterised latency and a registered ready/error response.
module data_bus_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [1:0]  bus_size,
    input  logic        bus_wren,
    input  logic        bus_rden,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        bus_err
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN    = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;
    logic        berr_q, berr_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] idx_s;
    logic [4:0]    shift_s;
    logic [31:0]   mask_s;
    logic          we_s;

    function automatic logic req_error(input logic [31:0] addr, input logic [1:0] size,
                                       input logic wr, input logic rd);
        logic [31:0] off;
        logic        bad;
        off = addr - BASE_ADDR;
        bad = 1'b0;
        if (wr && rd)                               bad = 1'b1;
        if (size == 2'b11)                          bad = 1'b1;
        if (size == 2'b01 && addr[0])               bad = 1'b1;
        if (size == 2'b10 && addr[1:0] != 2'b00)    bad = 1'b1;
        if (addr < BASE_ADDR)                       bad = 1'b1;
        if ({1'b0, off} >= SPAN)                    bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        logic [31:0] m;
        case (size)
            2'b00:   m = 32'h0000_00FF;
            2'b01:   m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    // State, latched request and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            berr_q  <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            berr_q  <= berr_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state; the *_d request fields always describe the request heading into RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus_wren || bus_rden) begin
                    addr_d  = bus_addr;
                    wdata_d = bus_wdata;
                    size_d  = bus_size;
                    wr_d    = bus_wren;
                    rd_d    = bus_rden;
                    err_d   = req_error(bus_addr, bus_size, bus_wren, bus_rden);
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = S_RESP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Response values are computed on the edge that enters RESP
    always_comb begin
        idx_s   = AW'((addr_d - BASE_ADDR) >> 2);
        shift_s = {addr_d[1:0], 3'b000};
        mask_s  = size_mask(size_d) << shift_s;
        ready_d = (state_d == S_RESP);
        berr_d  = (state_d == S_RESP) && err_d;
        we_s    = (state_d == S_RESP) && wr_d && !err_d;
        if ((state_d == S_RESP) && rd_d && !err_d) begin
            rdata_d = (mem[idx_s] >> shift_s) & size_mask(size_d);
        end else begin
            rdata_d = 32'd0;
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (we_s && !rst) begin
            mem[idx_s] <= (mem[idx_s] & ~mask_s) | ((wdata_d << shift_s) & mask_s);
        end
    end

    assign bus_ready = ready_q;
    assign bus_err   = berr_q;
    assign bus_rdata = rdata_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench: three responders (WAIT_STATES 1, 0, 3) share clock, reset and request bus.
module tb_data_bus_responder;

    localparam logic [31:0] B = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [1:0]  size = 2'd0;
    logic        wren_a [3];
    logic        rden_a [3];
    logic [31:0] rdata_a [3];
    logic        ready_a [3];
    logic        err_a [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_bus_responder #(.WAIT_STATES(1)) u_dut_ws1 (
        .clk(clk), .rst(rst), .bus_addr(addr), .bus_wdata(wdata), .bus_size(size),
        .bus_wren(wren_a[0]), .bus_rden(rden_a[0]),
        .bus_rdata(rdata_a[0]), .bus_ready(ready_a[0]), .bus_err(err_a[0]));

    data_bus_responder #(.WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .rst(rst), .bus_addr(addr), .bus_wdata(wdata), .bus_size(size),
        .bus_wren(wren_a[1]), .bus_rden(rden_a[1]),
        .bus_rdata(rdata_a[1]), .bus_ready(ready_a[1]), .bus_err(err_a[1]));

    data_bus_responder #(.WAIT_STATES(3)) u_dut_ws3 (
        .clk(clk), .rst(rst), .bus_addr(addr), .bus_wdata(wdata), .bus_size(size),
        .bus_wren(wren_a[2]), .bus_rden(rden_a[2]),
        .bus_rdata(rdata_a[2]), .bus_ready(ready_a[2]), .bus_err(err_a[2]));

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic [31:0] er, input logic ee);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.wdata = wd; v.size = sz;
        v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    // One request on DUT d; cycle 0 is the cycle in which the request is sampled
    task automatic run_txn(input int d, input logic wr, input logic rd, input logic [31:0] a,
                           input logic [31:0] wd, input logic [1:0] sz,
                           output int lat, output logic [31:0] rdat, output logic e);
        @(negedge clk);
        addr = a; wdata = wd; size = sz;
        wren_a[d] = wr; rden_a[d] = rd;
        lat = -1; rdat = 32'd0; e = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ready_a[d]) begin
                lat = c; rdat = rdata_a[d]; e = err_a[d];
                break;
            end else begin
                check("rdata_not_ready", rdata_a[d], 32'd0);
            end
        end
        wren_a[d] = 1'b0; rden_a[d] = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] rd_v;
        logic        e_v;

        for (int i = 0; i < 3; i++) begin
            wren_a[i] = 1'b0;
            rden_a[i] = 1'b0;
        end

        // vectors for the WAIT_STATES=1 instance, applied in order
        add(1'b1, 1'b0, B,                32'hDEAD_BEEF, 2'b10, 32'h0000_0000, 1'b0);
        add(1'b0, 1'b1, B,                32'h0,         2'b10, 32'hDEAD_BEEF, 1'b0);
        add(1'b1, 1'b0, B,                32'h1122_3344, 2'b10, 32'h0000_0000, 1'b0);
        add(1'b1, 1'b0, B + 32'd2,        32'hFFFF_FF5A, 2'b00, 32'h0000_0000, 1'b0);
        add(1'b0, 1'b1, B,                32'h0,         2'b10, 32'h115A_3344, 1'b0);
        add(1'b0, 1'b1, B + 32'd2,        32'h0,         2'b00, 32'h0000_005A, 1'b0);
        add(1'b0, 1'b1, B + 32'd2,        32'h0,         2'b01, 32'h0000_115A, 1'b0);
        add(1'b0, 1'b1, B + 32'd3,        32'h0,         2'b00, 32'h0000_0011, 1'b0);
        add(1'b1, 1'b0, B,                32'h1234_ABCD, 2'b01, 32'h0000_0000, 1'b0);
        add(1'b0, 1'b1, B,                32'h0,         2'b10, 32'h115A_ABCD, 1'b0);
        add(1'b0, 1'b1, B + 32'd1,        32'h0,         2'b10, 32'h0000_0000, 1'b1);
        add(1'b1, 1'b0, B + 32'd3,        32'h0000_5555, 2'b01, 32'h0000_0000, 1'b1);
        add(1'b0, 1'b1, 32'h1000_FFFC,    32'h0,         2'b10, 32'h0000_0000, 1'b1);
        add(1'b0, 1'b1, B,                32'h0,         2'b11, 32'h0000_0000, 1'b1);
        add(1'b1, 1'b1, B,                32'hFFFF_FFFF, 2'b10, 32'h0000_0000, 1'b1);
        add(1'b1, 1'b0, B + 32'hFFC,      32'h0BAD_F00D, 2'b10, 32'h0000_0000, 1'b0);
        add(1'b1, 1'b0, B + 32'h1000,     32'h7777_7777, 2'b10, 32'h0000_0000, 1'b1);
        add(1'b0, 1'b1, B + 32'hFFC,      32'h0,         2'b10, 32'h0BAD_F00D, 1'b0);
        add(1'b0, 1'b1, B,                32'h0,         2'b10, 32'h115A_ABCD, 1'b0);
        add(1'b0, 1'b1, B,                32'h0,         2'b01, 32'h0000_ABCD, 1'b0);

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_ready", 32'(ready_a[i]), 32'd0);
            check("reset_err",   32'(err_a[i]),   32'd0);
            check("reset_rdata", rdata_a[i],      32'd0);
        end
        rst = 1'b0;

        foreach (vecs[k]) begin
            run_txn(0, vecs[k].wr, vecs[k].rd, vecs[k].addr, vecs[k].wdata, vecs[k].size, lat, rd_v, e_v);
            check($sformatf("vec%0d_latency", k), 32'(lat), 32'd2);
            check($sformatf("vec%0d_rdata", k), rd_v, vecs[k].exp_rdata);
            check($sformatf("vec%0d_err", k), 32'(e_v), 32'(vecs[k].exp_err));
        end

        // zero wait states: ready in cycle 1
        run_txn(1, 1'b1, 1'b0, B + 32'h10, 32'h0102_0304, 2'b10, lat, rd_v, e_v);
        check("ws0_store_latency", 32'(lat), 32'd1);
        check("ws0_store_err", 32'(e_v), 32'd0);
        run_txn(1, 1'b0, 1'b1, B + 32'h10, 32'h0, 2'b10, lat, rd_v, e_v);
        check("ws0_load_latency", 32'(lat), 32'd1);
        check("ws0_load_rdata", rd_v, 32'h0102_0304);

        // held load, WAIT_STATES=1: one response every 3 cycles
        @(negedge clk);
        addr = B; size = 2'b10; rden_a[0] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check($sformatf("b2b_ws1_ready_c%0d", c), 32'(ready_a[0]), 32'((c % 3) == 2));
            if (ready_a[0]) check("b2b_ws1_rdata", rdata_a[0], 32'h115A_ABCD);
        end
        rden_a[0] = 1'b0;
        repeat (3) @(negedge clk);

        // held load, WAIT_STATES=0: one response every 2 cycles
        addr = B + 32'h10; size = 2'b10; rden_a[1] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("b2b_ws0_ready_c%0d", c), 32'(ready_a[1]), 32'((c % 2) == 1));
            if (ready_a[1]) check("b2b_ws0_rdata", rdata_a[1], 32'h0102_0304);
        end
        rden_a[1] = 1'b0;
        repeat (3) @(negedge clk);

        // WAIT_STATES=3: reset in cycle 2 aborts a store
        run_txn(2, 1'b1, 1'b0, B + 32'h20, 32'h55AA_55AA, 2'b10, lat, rd_v, e_v);
        check("ws3_store_latency", 32'(lat), 32'd4);
        run_txn(2, 1'b0, 1'b1, B + 32'h20, 32'h0, 2'b10, lat, rd_v, e_v);
        check("ws3_load_latency", 32'(lat), 32'd4);
        check("ws3_load_rdata", rd_v, 32'h55AA_55AA);

        @(negedge clk);
        addr = B + 32'h20; wdata = 32'hCAFE_F00D; size = 2'b10; wren_a[2] = 1'b1;
        @(negedge clk);
        check("abort_ready_c1", 32'(ready_a[2]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wren_a[2] = 1'b0;
        #1;
        check("abort_rst_ready", 32'(ready_a[2]), 32'd0);
        check("abort_rst_rdata", rdata_a[2], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("abort_no_ready", 32'(ready_a[2]), 32'd0);
        end
        run_txn(2, 1'b0, 1'b1, B + 32'h20, 32'h0, 2'b10, lat, rd_v, e_v);
        check("abort_reload_latency", 32'(lat), 32'd4);
        check("abort_reload_rdata", rd_v, 32'h55AA_55AA);
        check("abort_reload_err", 32'(e_v), 32'd0);

        // storage of another instance survives the reset
        run_txn(0, 1'b0, 1'b1, B, 32'h0, 2'b10, lat, rd_v, e_v);
        check("post_reset_latency", 32'(lat), 32'd2);
        check("post_reset_rdata", rd_v, 32'h115A_ABCD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
